// File: rtl/regfile_sequencer.sv
// Command sequencer for a 4-entry single-port register file: splits LOAD/READ/MOV/XCHG
// into the read and write cycles the file needs and returns one response per command.
module regfile_sequencer #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_dst,
  input  logic [SEL_W-1:0]  cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [SEL_W-1:0]  rf_reg_select,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_MOV  = 2'b10;
  localparam logic [1:0] OP_XCHG = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, RESP} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [SEL_W-1:0]  dst;
    logic [SEL_W-1:0]  src;
    logic [DATA_W-1:0] imm;
  } cmd_t;

  state_t            state, state_nxt;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] tmp_a, tmp_b, rsp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rf_reg_select   = '0;
    rf_write_enable = 1'b0;
    rf_data_in      = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_op == OP_LOAD) ? WR_A : RD_A;
      end
      RD_A: begin
        rf_reg_select = cmd_q.src;
        case (cmd_q.op)
          OP_READ: state_nxt = RESP;
          OP_MOV:  state_nxt = WR_A;
          default: state_nxt = RD_B;
        endcase
      end
      RD_B: begin
        rf_reg_select = cmd_q.dst;
        state_nxt     = WR_A;
      end
      WR_A: begin
        rf_reg_select   = cmd_q.dst;
        rf_write_enable = 1'b1;
        rf_data_in      = (cmd_q.op == OP_LOAD) ? cmd_q.imm : tmp_a;
        state_nxt       = (cmd_q.op == OP_XCHG) ? WR_B : RESP;
      end
      WR_B: begin
        rf_reg_select   = cmd_q.src;
        rf_write_enable = 1'b1;
        rf_data_in      = tmp_b;
        state_nxt       = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response value is captured on the way into RESP so it stays frozen under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
      tmp_a <= '0;
      tmp_b <= '0;
      rsp_q <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) cmd_q <= '{op: cmd_op, dst: cmd_dst, src: cmd_src, imm: cmd_imm};
        RD_A: begin
          tmp_a <= rf_data_out;
          if (cmd_q.op == OP_READ) rsp_q <= rf_data_out;
        end
        RD_B: tmp_b <= rf_data_out;
        WR_A: begin
          if (cmd_q.op == OP_LOAD)     rsp_q <= cmd_q.imm;
          else if (cmd_q.op == OP_MOV) rsp_q <= tmp_a;
        end
        WR_B: rsp_q <= tmp_b;
        default: ;
      endcase
    end
  end

  assign rsp_data = rsp_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register-file model predicts responses,
// write sequences and latency; a negedge monitor compares every cycle.
module tb_regfile_sequencer;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam logic [1:0] LOAD = 2'd0, READ = 2'd1, MOV = 2'd2, XCHG = 2'd3;
  localparam logic [1:0] AX = 2'd0, BX = 2'd1, CX = 2'd2, DX = 2'd3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [SW-1:0] cmd_dst = '0, cmd_src = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [SW-1:0] rf_reg_select;
  logic          rf_write_enable;
  logic [DW-1:0] rf_data_in;
  logic [DW-1:0] rf_data_out;

  always #5 clk = ~clk;

  regfile_sequencer #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rf_reg_select(rf_reg_select), .rf_write_enable(rf_write_enable),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  // Environment: the register file itself
  logic [DW-1:0] rf [4];
  initial for (int i = 0; i < 4; i++) rf[i] = '0;
  assign rf_data_out = rf[rf_reg_select];
  always @(posedge clk) if (rf_write_enable) rf[rf_reg_select] <= rf_data_in;

  // Architectural model and expectations
  logic [DW-1:0] m [4];
  initial for (int i = 0; i < 4; i++) m[i] = '0;
  int            n_vec = 0, n_err = 0;
  bit            busy = 0, prev_busy = 0, seen = 0;
  int            cyc = 0, widx = 0, exp_lat = 0, last_lat = 0;
  logic [17:0]   exp_wr[$];
  logic [17:0]   obs_wr[$];
  logic [DW-1:0] exp_rsp = '0, last_rsp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!prev_busy) begin cyc = 1; widx = 0; seen = 0; obs_wr.delete(); end
        else cyc++;
        chk("busy_cmd_ready", cmd_ready, 0);
        if (rf_write_enable) begin
          obs_wr.push_back({rf_reg_select, rf_data_in});
          if (widx < exp_wr.size()) begin
            chk("wr_sel", rf_reg_select, exp_wr[widx][17:16]);
            chk("wr_data", rf_data_in, exp_wr[widx][15:0]);
          end else chk("write_count", widx + 1, exp_wr.size());
          widx++;
        end else chk("nowr_data_in", rf_data_in, 0);
        if (rsp_valid) begin
          if (!seen) begin
            chk("latency", cyc, exp_lat);
            chk("writes_done", widx, exp_wr.size());
            last_lat = cyc;
            last_rsp = rsp_data;
            seen = 1;
          end
          chk("rsp_data", rsp_data, exp_rsp);
          chk("rsp_sel", rf_reg_select, 0);
        end
      end else begin
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_we", rf_write_enable, 0);
        chk("idle_data_in", rf_data_in, 0);
        chk("idle_sel", rf_reg_select, 0);
      end
      prev_busy = busy;
    end
  end

  task automatic predict(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                         input logic [DW-1:0] imm);
    exp_wr.delete();
    case (op)
      LOAD: begin exp_wr.push_back({dst, imm}); exp_rsp = imm; exp_lat = 2; end
      READ: begin exp_rsp = m[src]; exp_lat = 2; end
      MOV:  begin exp_wr.push_back({dst, m[src]}); exp_rsp = m[src]; exp_lat = 3; end
      default: begin
        exp_wr.push_back({dst, m[src]});
        exp_wr.push_back({src, m[dst]});
        exp_rsp = m[dst];
        exp_lat = 5;
      end
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                       input logic [DW-1:0] imm, input logic rdy);
    @(posedge clk); #1;
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    cmd_valid = 1'b1; rsp_ready = rdy;
    @(posedge clk);
    busy = 1;
    #1;
    // later cmd_* changes must be ignored
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_dst = 2'($urandom); cmd_src = 2'($urandom); cmd_imm = 16'($urandom);
  endtask

  task automatic run(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                     input logic [DW-1:0] imm, input int stall);
    int n;
    predict(op, dst, src, imm);
    issue(op, dst, src, imm, stall == 0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rsp_arrives", rsp_valid, 1);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk);
    busy = 0;
    foreach (exp_wr[i]) m[exp_wr[i][17:16]] = exp_wr[i][15:0];
  endtask

  typedef struct { logic [1:0] op, dst, src; logic [15:0] imm; } vec_t;
  vec_t tbl [6];

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_sel", rf_reg_select, 0);
    chk("rst_we", rf_write_enable, 0);
    chk("rst_data_in", rf_data_in, 0);

    // LOAD / READ
    run(LOAD, AX, BX, 16'h1234, 0);
    chk("load_rsp_lit", last_rsp, 16'h1234);
    chk("load_lat_lit", last_lat, 2);
    chk("load_wr_lit", obs_wr.size() == 1 ? obs_wr[0] : 18'h3ffff, {2'b00, 16'h1234});
    run(READ, CX, AX, 16'h0, 0);
    chk("read_ax_lit", last_rsp, 16'h1234);

    // MOV
    run(LOAD, BX, AX, 16'hBEEF, 0);
    run(MOV, DX, BX, 16'h0, 0);
    chk("mov_rsp_lit", last_rsp, 16'hBEEF);
    chk("mov_lat_lit", last_lat, 3);
    run(READ, AX, DX, 16'h0, 0);
    chk("read_dx_lit", last_rsp, 16'hBEEF);
    run(READ, AX, BX, 16'h0, 0);
    chk("read_bx_lit", last_rsp, 16'hBEEF);

    // XCHG
    run(LOAD, BX, AX, 16'hAAAA, 0);
    run(LOAD, CX, AX, 16'h5555, 0);
    run(XCHG, BX, CX, 16'h0, 0);
    chk("xchg_rsp_lit", last_rsp, 16'hAAAA);
    chk("xchg_lat_lit", last_lat, 5);
    chk("xchg_nwr_lit", obs_wr.size(), 2);
    if (obs_wr.size() == 2) begin
      chk("xchg_wr0_lit", obs_wr[0], {2'b01, 16'h5555});
      chk("xchg_wr1_lit", obs_wr[1], {2'b10, 16'hAAAA});
    end
    run(READ, AX, BX, 16'h0, 0);
    chk("read_bx_x_lit", last_rsp, 16'h5555);
    run(READ, AX, CX, 16'h0, 0);
    chk("read_cx_x_lit", last_rsp, 16'hAAAA);
    run(XCHG, AX, AX, 16'h0, 0);
    chk("xchg_same_lit", last_rsp, 16'h1234);
    run(READ, BX, AX, 16'h0, 0);
    chk("read_ax_same_lit", last_rsp, 16'h1234);
    run(MOV, CX, CX, 16'h0, 0);
    chk("mov_same_lit", last_rsp, 16'hAAAA);

    // Backpressure
    run(READ, AX, DX, 16'h0, 4);
    chk("bp_read_lit", last_rsp, 16'hBEEF);
    run(XCHG, DX, AX, 16'h0, 4);
    run(LOAD, CX, AX, 16'h7E57, 3);

    // Directed mix
    tbl[0] = '{LOAD, AX, BX, 16'hFFFF};
    tbl[1] = '{MOV,  BX, AX, 16'h0};
    tbl[2] = '{XCHG, CX, BX, 16'h0};
    tbl[3] = '{LOAD, DX, AX, 16'h0000};
    tbl[4] = '{XCHG, DX, AX, 16'h0};
    tbl[5] = '{READ, AX, CX, 16'h0};
    foreach (tbl[i]) run(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].imm, i % 2);

    // Reset during RD_B of an XCHG
    predict(XCHG, BX, CX, 16'h0);
    issue(XCHG, BX, CX, 16'h0, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    busy = 0;
    #1;
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_rsp_data", rsp_data, 0);
    chk("mrst_we", rf_write_enable, 0);
    chk("mrst_sel", rf_reg_select, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    run(LOAD, DX, AX, 16'h0F0F, 0);
    chk("post_rst_load_lit", last_rsp, 16'h0F0F);
    run(READ, AX, DX, 16'h0, 0);
    chk("post_rst_read_lit", last_rsp, 16'h0F0F);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven initiator for the 4-entry, 16-bit, single-port register file (AX/BX/CX/DX). It accepts LOAD/READ/MOV/XCHG commands over a valid/ready handshake and breaks each one into the single-port read and write cycles the register file needs. It returns one response per command over a second valid/ready handshake. It sits between the instruction control path and the register file and is the only driver of the register file's select, write-enable and data-in pins.

## Interface
- DATA_W, 16, register data width
- SEL_W, 2, register select width (4 registers: 00=AX, 01=BX, 10=CX, 11=DX)

- clk  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00=LOAD, 01=READ, 10=MOV, 11=XCHG
- cmd_dst  in  SEL_W  destination register
- cmd_src  in  SEL_W  source register
- cmd_imm  in  DATA_W  immediate value for LOAD
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  response value
- rf_reg_select  out  SEL_W  register file select; the same select drives both read and write
- rf_write_enable  out  1  register file write strobe
- rf_data_in  out  DATA_W  register file write data
- rf_data_out  in  DATA_W  register file read data; combinational from rf_reg_select

## Operation
- FSM states: IDLE, RD_A, RD_B, WR_A, WR_B, RESP.
- Command acceptance:
  - cmd_ready = 1 only in IDLE.
  - A command is accepted when cmd_valid & cmd_ready at a clock edge.
  - op, dst, src and imm are latched at acceptance; later changes on the cmd_* inputs are ignored.
- State sequences after acceptance:
  - LOAD: IDLE -> WR_A -> RESP.
  - READ: IDLE -> RD_A -> RESP.
  - MOV: IDLE -> RD_A -> WR_A -> RESP.
  - XCHG: IDLE -> RD_A -> RD_B -> WR_A -> WR_B -> RESP.
- Read states:
  - RD_A: rf_reg_select = src; tmp_a <= rf_data_out.
  - RD_B: rf_reg_select = dst; tmp_b <= rf_data_out.
- Write states (only here is rf_write_enable = 1):
  - WR_A: rf_reg_select = dst; rf_data_in = imm for LOAD, tmp_a for MOV/XCHG.
  - WR_B: rf_reg_select = src; rf_data_in = tmp_b.
- Outside write states: rf_write_enable = 0 and rf_data_in = 0.
- rf_reg_select = 00 in IDLE and RESP.
- Response data:
  - LOAD: imm.
  - READ: value of src.
  - MOV: value moved.
  - XCHG: old value of dst.
- RESP behaviour:
  - rsp_valid = 1 only in RESP.
  - rsp_data is held stable until rsp_valid & rsp_ready, then the FSM goes to IDLE.
  - A new command is not accepted in the same cycle as the response handshake.
- Boundary cases:
  - MOV with src == dst: performs the read and writes back the same value.
  - XCHG with src == dst: register unchanged; rsp_data = its value.
- Unknown states recover to IDLE.

## Timing
- Accept edge is cycle 0. Earliest rsp_valid:
  - LOAD and READ: cycle 2.
  - MOV: cycle 3.
  - XCHG: cycle 5.
- Throughput: at most one command per (latency + 1) cycles.
- Each write state asserts rf_write_enable for exactly one cycle; the register file updates at the end of that cycle.
- A read in the cycle after a write observes the new value.
- Reset values:
  - Outputs: cmd_ready = 1, rsp_valid = 0, rsp_data = 0, rf_reg_select = 00, rf_write_enable = 0, rf_data_in = 0.
  - Internal: tmp_a = tmp_b = 0, state = IDLE.
- Reset asserted mid-command forces IDLE immediately, with no pending response. A partially executed XCHG may leave the register file half-updated; the register file shares reset in the normal system, so that case does not arise there.
- rsp_ready low stalls only the RESP state; register file pins stay idle while stalled.

## Test plan
- Reset check: hold reset_n = 0 for 3 cycles, then release. Require all outputs at their reset values and cmd_ready = 1.
- LOAD: LOAD AX, 0x1234. Require rf_write_enable high for one cycle with rf_reg_select = 00 and rf_data_in = 0x1234, then rsp_valid with rsp_data = 0x1234 at cycle 2. A following READ AX must return 0x1234.
- MOV: preload BX = 0xBEEF, issue MOV DX <- BX. Require response 0xBEEF at cycle 3; READ DX returns 0xBEEF and READ BX still returns 0xBEEF.
- XCHG: BX = 0xAAAA, CX = 0x5555, issue XCHG dst = BX, src = CX. Require the register file write sequence (sel 01, 0x5555) then (sel 10, 0xAAAA), and rsp_data = 0xAAAA at cycle 5. XCHG with src == dst = AX must leave AX unchanged.
- Backpressure: hold rsp_ready = 0 for 4 cycles after rsp_valid rises. Require rsp_data stable, cmd_ready = 0, and rf_write_enable = 0 throughout. Require a single handshake when rsp_ready rises and cmd_ready = 1 on the next cycle.
- Reset mid-XCHG: assert reset_n = 0 during RD_B. Require the same-cycle return to reset output values, no rsp_valid after release, and a subsequent LOAD that completes normally.
